// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, ALU encodings, FSM states and control bundle for the lab CPU sequencer
// Contents:
//   OP_*     8-bit instruction opcodes
//   ALU_*    4-bit ALU select encodings
//   state_t  sequencer FSM states
//   ctrl_t   decoded control bundle produced by instr_decoder
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_MULT  = 8'h09;
    localparam logic [7:0] OP_SLL   = 8'h0A;
    localparam logic [7:0] OP_SRL   = 8'h0B;
    localparam logic [7:0] OP_SRA   = 8'h0C;
    localparam logic [7:0] OP_ROR   = 8'h0D;

    localparam logic [3:0] ALU_MOV  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_ROR  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       neg_sel;
        logic       imm_sel;
        logic       writes;
        logic       is_branch;
        logic       branch_ne;
        logic       is_jump;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode to control-bundle decode
// Ports:
//   opcode  in   8   instruction opcode field
//   ctrl    out  11  packed ctrl_t bundle
// Macro EXT_OPS_EN enables mult and the shift opcodes; without it they decode as illegal.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0]               opcode,
    output logic [$bits(ctrl_t)-1:0] ctrl
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (opcode)
            OP_LOADI: begin c.imm_sel = 1'b1; c.writes = 1'b1; end
            OP_MOV:   c.writes = 1'b1;
            OP_ADD:   begin c.aluop = ALU_ADD; c.writes = 1'b1; end
            OP_SUB:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.writes = 1'b1; end
            OP_AND:   begin c.aluop = ALU_AND; c.writes = 1'b1; end
            OP_OR:    begin c.aluop = ALU_OR; c.writes = 1'b1; end
            OP_J:     c.is_jump = 1'b1;
            OP_BEQ:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.is_branch = 1'b1; end
            OP_BNE:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.is_branch = 1'b1; c.branch_ne = 1'b1; end
`ifdef EXT_OPS_EN
            OP_MULT:  begin c.aluop = ALU_MULT; c.writes = 1'b1; end
            OP_SLL:   begin c.aluop = ALU_SLL; c.imm_sel = 1'b1; c.writes = 1'b1; end
            OP_SRL:   begin c.aluop = ALU_SRL; c.imm_sel = 1'b1; c.writes = 1'b1; end
            OP_SRA:   begin c.aluop = ALU_SRA; c.imm_sel = 1'b1; c.writes = 1'b1; end
            OP_ROR:   begin c.aluop = ALU_ROR; c.imm_sel = 1'b1; c.writes = 1'b1; end
`endif
            default:  c.illegal = 1'b1;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: IDLE/EXEC/WB control sequencer driving the lab CPU ALU and register file
// Ports:
//   CLK, RESET (async active-low)
//   INSTRUCTION, INSTR_VALID, INSTR_READY   instruction handshake
//   ZERO                                    ALU zero flag, resolves beq/bne
//   ALUOP, NEG_SEL, IMM_SEL, IMMEDIATE      ALU controls, held from accept until next accept
//   READREG1, READREG2, WRITEREG, OFFSET    register/offset fields, held likewise
//   WRITEENABLE, BRANCH_TAKEN, JUMP_TAKEN, ILLEGAL   one-cycle WB pulses
// Macro EXT_OPS_EN enables mult/shift decode and the MULT_WAIT down-counter.
module instruction_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_WAIT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic        ZERO,
    output logic [3:0]  ALUOP,
    output logic        NEG_SEL,
    output logic        IMM_SEL,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic        WRITEENABLE,
    output logic        BRANCH_TAKEN,
    output logic        JUMP_TAKEN,
    output logic [7:0]  OFFSET,
    output logic        ILLEGAL
);

    if (MULT_WAIT < 0 || MULT_WAIT > 7) begin : g_bad_wait
        $error("MULT_WAIT must be in 0..7");
    end

    state_t                   state, state_nx;
    logic [$bits(ctrl_t)-1:0] dec_raw;
    ctrl_t                    dec;
    logic                     accept, exec_done, leave;
    logic                     wb_write, wb_branch, wb_ne, wb_jump, wb_illegal;
    logic                     unused_bits;

    instr_decoder u_dec (.opcode(INSTRUCTION[31:24]), .ctrl(dec_raw));

    assign dec         = ctrl_t'(dec_raw);
    assign unused_bits = ^{INSTRUCTION[15:11], INSTRUCTION[7:3]};
    assign INSTR_READY = (state == S_IDLE) & RESET;
    assign accept      = INSTR_VALID & INSTR_READY;
    assign leave       = (state == S_EXEC) & exec_done;

`ifdef EXT_OPS_EN
    // Counts the extra EXEC cycles of a mult; zero means this is the last EXEC cycle.
    logic [2:0] cnt;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cnt <= '0;
        else if (accept)
            cnt <= (dec.aluop == ALU_MULT) ? 3'(MULT_WAIT) : 3'd0;
        else if (state == S_EXEC && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end
    assign exec_done = (cnt == 3'd0);
`else
    assign exec_done = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = accept ? S_EXEC : S_IDLE;
            S_EXEC:  state_nx = exec_done ? S_WB : S_EXEC;
            default: state_nx = S_IDLE;
        endcase
    end

    // Controls are captured at accept and held; WB pulses are registered on the edge leaving EXEC.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ALUOP        <= '0;
            NEG_SEL      <= 1'b0;
            IMM_SEL      <= 1'b0;
            IMMEDIATE    <= '0;
            READREG1     <= '0;
            READREG2     <= '0;
            WRITEREG     <= '0;
            OFFSET       <= '0;
            wb_write     <= 1'b0;
            wb_branch    <= 1'b0;
            wb_ne        <= 1'b0;
            wb_jump      <= 1'b0;
            wb_illegal   <= 1'b0;
            WRITEENABLE  <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            JUMP_TAKEN   <= 1'b0;
            ILLEGAL      <= 1'b0;
        end else begin
            if (accept) begin
                ALUOP      <= dec.aluop;
                NEG_SEL    <= dec.neg_sel;
                IMM_SEL    <= dec.imm_sel;
                IMMEDIATE  <= INSTRUCTION[7:0];
                READREG1   <= INSTRUCTION[10:8];
                READREG2   <= INSTRUCTION[2:0];
                WRITEREG   <= INSTRUCTION[18:16];
                OFFSET     <= INSTRUCTION[23:16];
                wb_write   <= dec.writes;
                wb_branch  <= dec.is_branch;
                wb_ne      <= dec.branch_ne;
                wb_jump    <= dec.is_jump;
                wb_illegal <= dec.illegal;
            end
            WRITEENABLE  <= leave & wb_write;
            BRANCH_TAKEN <= leave & wb_branch & (ZERO ^ wb_ne);
            JUMP_TAKEN   <= leave & wb_jump;
            ILLEGAL      <= leave & wb_illegal;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: randomized and directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

    localparam int MW = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION = '0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic        ZERO = 1'b0;
    logic [3:0]  ALUOP;
    logic        NEG_SEL, IMM_SEL;
    logic [7:0]  IMMEDIATE, OFFSET;
    logic [2:0]  READREG1, READREG2, WRITEREG;
    logic        WRITEENABLE, BRANCH_TAKEN, JUMP_TAKEN, ILLEGAL;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    instruction_sequencer #(.MULT_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .ZERO(ZERO), .ALUOP(ALUOP), .NEG_SEL(NEG_SEL),
        .IMM_SEL(IMM_SEL), .IMMEDIATE(IMMEDIATE), .READREG1(READREG1), .READREG2(READREG2),
        .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE), .BRANCH_TAKEN(BRANCH_TAKEN),
        .JUMP_TAKEN(JUMP_TAKEN), .OFFSET(OFFSET), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    wire [30:0] ctrl_obs  = {ALUOP, NEG_SEL, IMM_SEL, IMMEDIATE, READREG1, READREG2, WRITEREG, OFFSET};
    wire [3:0]  pulse_obs = {WRITEENABLE, BRANCH_TAKEN, JUMP_TAKEN, ILLEGAL};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: ALU select per opcode 00..0D, straight from the opcode/ALUOP tables.
    int alu_tab [14] = '{0, 0, 1, 1, 2, 3, 0, 1, 1, 8, 5, 4, 7, 6};

    function automatic bit known_op(input logic [7:0] op);
`ifdef EXT_OPS_EN
        return op <= 8'h0D;
`else
        return op <= 8'h08;
`endif
    endfunction

    function automatic logic [30:0] exp_ctrl(input logic [31:0] ins);
        logic [7:0] op;
        logic [3:0] alu;
        logic       neg, imm;
        op  = ins[31:24];
        alu = known_op(op) ? 4'(alu_tab[op]) : 4'd0;
        neg = known_op(op) && (op == 8'h03 || op == 8'h07 || op == 8'h08);
        imm = known_op(op) && (op == 8'h00 || (op >= 8'h0A && op <= 8'h0D));
        return {alu, neg, imm, ins[7:0], ins[10:8], ins[2:0], ins[18:16], ins[23:16]};
    endfunction

    function automatic logic [3:0] exp_pulse(input logic [31:0] ins, input logic z);
        logic [7:0] op;
        logic       we, br, jt;
        op = ins[31:24];
        if (!known_op(op)) return 4'b0001;
        we = (op <= 8'h05) || (op >= 8'h09);
        br = (op == 8'h07 && z) || (op == 8'h08 && !z);
        jt = (op == 8'h06);
        return {we, br, jt, 1'b0};
    endfunction

    function automatic int exec_len(input logic [31:0] ins);
        return (known_op(ins[31:24]) && ins[31:24] == 8'h09) ? 1 + MW : 1;
    endfunction

    // Wait (bounded) for READY with VALID up; returns once the next posedge will accept.
    task automatic offer(input logic [31:0] ins);
        int n;
        @(negedge CLK);
        INSTRUCTION = ins;
        INSTR_VALID = 1'b1;
        n = 0;
        while (!INSTR_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
    endtask

    // One full transaction; VALID stays high with scrambled INSTRUCTION while busy.
    task automatic run(input string tag, input logic [31:0] ins, input logic z);
        logic [30:0] c;
        int          ex;
        c  = exp_ctrl(ins);
        ex = exec_len(ins);
        offer(ins);
        for (int k = 1; k <= ex; k++) begin
            @(negedge CLK);
            chk({tag, "_exec_ctrl"}, 32'(ctrl_obs), 32'(c));
            chk({tag, "_exec_pulse"}, 32'(pulse_obs), 32'd0);
            chk({tag, "_exec_ready"}, 32'(INSTR_READY), 32'd0);
            INSTRUCTION = $urandom;
            ZERO = (k == ex) ? z : ~z;
        end
        @(negedge CLK);
        chk({tag, "_wb_pulse"}, 32'(pulse_obs), 32'(exp_pulse(ins, z)));
        chk({tag, "_wb_ctrl"}, 32'(ctrl_obs), 32'(c));
        chk({tag, "_wb_ready"}, 32'(INSTR_READY), 32'd0);
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        chk({tag, "_idle_pulse"}, 32'(pulse_obs), 32'd0);
        chk({tag, "_idle_ctrl"}, 32'(ctrl_obs), 32'(c));
        chk({tag, "_idle_ready"}, 32'(INSTR_READY), 32'd1);
    endtask

    initial begin
        logic [31:0] ins;
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl_obs), 32'd0);
        chk("rst_pulse", 32'(pulse_obs), 32'd0);
        chk("rst_ready", 32'(INSTR_READY), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        #1 chk("rst_release_ready", 32'(INSTR_READY), 32'd1);

        run("loadi", {8'h00, 8'h03, 8'h00, 8'h2A}, 1'b0);
        run("sub", {8'h03, 8'h01, 8'h02, 8'h04}, 1'b0);
        run("beq_z1", {8'h07, 8'hFE, 8'h01, 8'h02}, 1'b1);
        run("bne_z1", {8'h08, 8'hFE, 8'h01, 8'h02}, 1'b1);
        run("bne_z0", {8'h08, 8'h10, 8'h05, 8'h06}, 1'b0);
        run("jump", {8'h06, 8'h7F, 8'h00, 8'h00}, 1'b0);
        run("mult", {8'h09, 8'h05, 8'h03, 8'h01}, 1'b0);
        run("sll", {8'h0A, 8'h02, 8'h01, 8'h03}, 1'b0);
        run("unknown", {8'hFF, 8'h12, 8'h34, 8'h56}, 1'b1);

        // Reset during the EXEC phase of a mult: outputs clear asynchronously, no WB follows.
        offer({8'h09, 8'h04, 8'h05, 8'h06});
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_ctrl", 32'(ctrl_obs), 32'd0);
        chk("midrst_pulse", 32'(pulse_obs), 32'd0);
        chk("midrst_ready", 32'(INSTR_READY), 32'd0);
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("midrst_after_pulse", 32'(pulse_obs), 32'd0);
            chk("midrst_after_ready", 32'(INSTR_READY), 32'd1);
        end

        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            ins[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            run("rand", ins, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
